// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word/state encodings plus the arbiter FSM and grant types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE,
    SERVE
  } arb_state_t;

  typedef struct packed {
    logic core;
    logic is_d;
  } arb_grant_t;

endpackage

// File: rtl/arb_pick.sv
// Fixed-order requester selection: d[rr], i[rr], d[~rr], i[~rr].
module arb_pick
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic [CPUS-1:0] ireq,
  input  logic [CPUS-1:0] dreq,
  input  logic            rr,
  output logic            vld,
  output arb_grant_t      grant
);

  logic orr;
  assign orr = ~rr;

  // Within the favoured core dcache wins; the other core only gets a look-in when rr is idle.
  always_comb begin
    vld   = 1'b0;
    grant = '0;
    if (dreq[rr]) begin
      vld        = 1'b1;
      grant.core = rr;
      grant.is_d = 1'b1;
    end else if (ireq[rr]) begin
      vld        = 1'b1;
      grant.core = rr;
      grant.is_d = 1'b0;
    end else if (dreq[orr]) begin
      vld        = 1'b1;
      grant.core = orr;
      grant.is_d = 1'b1;
    end else if (ireq[orr]) begin
      vld        = 1'b1;
      grant.core = orr;
      grant.is_d = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-core icache/dcache arbiter onto one RAM port; one transaction in flight, round-robin between cores.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                CLK,
  input  logic                n_rst,
  input  logic  [CPUS-1:0]    iREN,
  input  word_t [CPUS-1:0]    iaddr,
  output logic  [CPUS-1:0]    iwait,
  output word_t [CPUS-1:0]    iload,
  input  logic  [CPUS-1:0]    dREN,
  input  logic  [CPUS-1:0]    dWEN,
  input  word_t [CPUS-1:0]    daddr,
  input  word_t [CPUS-1:0]    dstore,
  output logic  [CPUS-1:0]    dwait,
  output word_t [CPUS-1:0]    dload,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  ramstate_t           ramstate
);

  arb_state_t state, state_n;
  arb_grant_t grant, pick;
  logic       rr, rr_n;
  logic       pick_vld;
  logic [CPUS-1:0] dreq;

  assign dreq = dREN | dWEN;

  arb_pick #(.CPUS(CPUS)) u_pick (
    .ireq  (iREN),
    .dreq  (dreq),
    .rr    (rr),
    .vld   (pick_vld),
    .grant (pick)
  );

  always_ff @(posedge CLK) begin
    if (!n_rst) begin
      state <= IDLE;
      rr    <= 1'b0;
      grant <= '0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
      if (state == IDLE && pick_vld) grant <= pick;
    end
  end

  // Granted requester's live signals, muxed by the registered grant.
  logic  g_req, g_wr;
  word_t g_addr;

  always_comb begin
    if (grant.is_d) begin
      g_req  = dreq[grant.core];
      g_wr   = dWEN[grant.core];
      g_addr = daddr[grant.core];
    end else begin
      g_req  = iREN[grant.core];
      g_wr   = 1'b0;
      g_addr = iaddr[grant.core];
    end
  end

  always_comb begin
    state_n  = state;
    rr_n     = rr;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    case (state)
      IDLE: begin
        if (pick_vld) state_n = SERVE;
      end
      SERVE: begin
        if (!g_req) begin
          // Abort: requester withdrew, leave the bus quiet and keep rr.
          state_n = IDLE;
        end else begin
          ramaddr = g_addr;
          if (g_wr) begin
            ramWEN   = 1'b1;
            ramstore = dstore[grant.core];
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == ACCESS) begin
            if (grant.is_d) dwait[grant.core] = 1'b0;
            else            iwait[grant.core] = 1'b0;
            rr_n    = ~grant.core;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar k = 0; k < CPUS; k++) begin : g_load
    assign iload[k] = ramload;
    assign dload[k] = ramload;
  end

endmodule
